// File: rtl/vx_tcu_fedp_seq.sv
// Tile-job sequencer for the tensor-core FEDP unit: streams TILES interleaved output elements
// round-robin through one fixed-latency FEDP. Define VX_TCU_SEQ_PERF_EN to add perf counters.
module vx_tcu_fedp_seq #(
    parameter int N        = 1,
    parameter int XLEN     = 32,
    parameter int LATENCY  = 4,
    parameter int TILES    = 8,
    parameter int KSTEPS_W = 4,
    localparam int TILE_W  = (TILES > 1) ? $clog2(TILES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_fmt_s,
    input  logic [3:0]            req_fmt_d,
    input  logic [KSTEPS_W-1:0]   req_ksteps,
    input  logic [TILES*32-1:0]   req_c,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [N*XLEN-1:0]     op_a_row,
    input  logic [N*XLEN-1:0]     op_b_col,
    output logic [TILE_W-1:0]     op_tile,
    output logic                  fedp_enable,
    output logic [3:0]            fedp_fmt_s,
    output logic [3:0]            fedp_fmt_d,
    output logic [N*XLEN-1:0]     fedp_a_row,
    output logic [N*XLEN-1:0]     fedp_b_col,
    output logic [31:0]           fedp_c_val,
    input  logic [31:0]           fedp_d_val,
`ifdef VX_TCU_SEQ_PERF_EN
    output logic [31:0]           perf_issues,
    output logic [31:0]           perf_stalls,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TILES*32-1:0]   rsp_d
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          fmt_s, fmt_d;
    logic [KSTEPS_W-1:0] ksteps, k_cur;
    logic [TILE_W-1:0]   t_cur;
    logic [TILES-1:0]    pending, pending_nxt, issue_mask, wb_mask;
    logic [LATENCY-1:0]  trk_vld, trk_vld_nxt;
    logic [TILE_W-1:0]   trk_tile [LATENCY];
    logic [31:0]         acc [TILES];
    logic                issue, t_wrap, last_issue, wb_vld;
    logic [TILE_W-1:0]   wb_tile;

    assign wb_vld      = trk_vld[LATENCY-1];
    assign wb_tile     = trk_tile[LATENCY-1];
    assign op_ready    = (state == ISSUE) && !pending[t_cur];
    assign issue       = op_valid && op_ready;
    assign t_wrap      = (t_cur == TILE_W'(TILES - 1));
    assign last_issue  = issue && t_wrap && (k_cur == ksteps);
    assign issue_mask  = issue ? (TILES'(1) << t_cur) : '0;
    assign wb_mask     = wb_vld ? (TILES'(1) << wb_tile) : '0;
    assign pending_nxt = (pending & ~wb_mask) | issue_mask;
    assign trk_vld_nxt = (trk_vld << 1) | LATENCY'(issue);

    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign fedp_enable = (state != IDLE);
    assign op_tile     = t_cur;
    assign fedp_fmt_s  = fmt_s;
    assign fedp_fmt_d  = fmt_d;
    assign fedp_a_row  = op_a_row;
    assign fedp_b_col  = op_b_col;
    assign fedp_c_val  = acc[t_cur];

    for (genvar g = 0; g < TILES; g++) begin : g_rsp
        assign rsp_d[g*32 +: 32] = acc[g];
    end

    // DRAIN looks at post-edge scoreboard state so RESP follows the final writeback directly
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (pending_nxt == '0 && trk_vld_nxt == '0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmt_s   <= '0;
            fmt_d   <= '0;
            ksteps  <= '0;
            k_cur   <= '0;
            t_cur   <= '0;
            pending <= '0;
            trk_vld <= '0;
            for (int i = 0; i < LATENCY; i++) trk_tile[i] <= '0;
            for (int i = 0; i < TILES; i++)   acc[i] <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                fmt_s  <= req_fmt_s;
                fmt_d  <= req_fmt_d;
                ksteps <= req_ksteps;
                k_cur  <= '0;
                t_cur  <= '0;
                for (int i = 0; i < TILES; i++) acc[i] <= req_c[i*32 +: 32];
            end
            if (issue) begin
                t_cur <= t_wrap ? '0 : t_cur + 1'b1;
                if (t_wrap) k_cur <= k_cur + 1'b1;
            end
            pending     <= pending_nxt;
            trk_vld     <= trk_vld_nxt;
            trk_tile[0] <= t_cur;
            for (int i = 1; i < LATENCY; i++) trk_tile[i] <= trk_tile[i-1];
            // Tracker slot valid only for real issues; FEDP output from bubbles never lands
            if (wb_vld) acc[wb_tile] <= fedp_d_val;
        end
    end

    wb_issue_collision: assert property (@(posedge clk) disable iff (!reset_n)
        !(issue && wb_vld && (wb_tile == t_cur)));

`ifdef VX_TCU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issues <= '0;
            perf_stalls <= '0;
        end else begin
            if (issue) perf_issues <= perf_issues + 32'd1;
            if (state == ISSUE && op_valid && !op_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: doc/vx_tcu_fedp_seq.md
# vx_tcu_fedp_seq

Sequencer for the tensor-core fused dot-product (FEDP) unit. It accepts one tile job: a format pair, a K-step count and TILES initial accumulators. It then streams operand pairs through a single fixed-latency FEDP instance, interleaving the independent output elements round-robin so the FEDP pipeline stays full. Each element's FEDP result is fed back as its next addend, and the finished tile is returned on a response handshake. It sits between the TCU operand-fetch logic and the FEDP datapath.

## Interface
- `N`, 1: FEDP dot-product width, in XLEN-wide lanes.
- `LATENCY`, 4: FEDP pipeline depth in cycles. Must be ≥ 1.
- `TILES`, 8: number of interleaved output elements. Must be ≥ 1.
- `KSTEPS_W`, 4: width of the K-step count.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: tile job request.
- `req_ready` out 1: job accepted.
- `req_fmt_s` in 4: source format, forwarded to the FEDP.
- `req_fmt_d` in 4: destination format, forwarded to the FEDP.
- `req_ksteps` in KSTEPS_W: number of K steps minus 1.
- `req_c` in TILES×32: initial accumulators.
- `op_valid` in 1: operand pair available.
- `op_ready` out 1: operand pair consumed this cycle.
- `op_a_row` in N×XLEN: A operand.
- `op_b_col` in N×XLEN: B operand.
- `op_tile` out clog2(TILES): element index the next operand pair is for.
- `fedp_enable` out 1: FEDP pipeline enable.
- `fedp_fmt_s` out 4: to FEDP.
- `fedp_fmt_d` out 4: to FEDP.
- `fedp_a_row` out N×XLEN: to FEDP.
- `fedp_b_col` out N×XLEN: to FEDP.
- `fedp_c_val` out 32: to FEDP.
- `fedp_d_val` in 32: FEDP result.
- `rsp_valid` out 1: finished tile available.
- `rsp_ready` in 1: response consumed.
- `rsp_d` out TILES×32: final accumulators.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: load `req_c` into the accumulator file, latch both formats and the step count, set the cursor to (k=0, t=0), and go to ISSUE.
- **ISSUE**
  - `op_ready` = `!pending[t]`. `op_tile` = t.
  - An issue occurs when `op_valid && op_ready`:
    - Drive `fedp_a_row`/`fedp_b_col` combinationally from the operand ports, and `fedp_c_val` = acc[t].
    - Set `pending[t]`.
    - Push {valid, t} into a LATENCY-deep tracking shift register.
    - Advance t. When t wraps from TILES−1 to 0, increment k.
  - The issue of (k=ksteps, t=TILES−1) moves the FSM to DRAIN.
- **DRAIN**
  - `op_ready` = 0.
  - Go to RESP when no pending bit is set and the shift register is empty.
- **Writeback** (all states)
  - When the shift register's output slot is valid, write acc[tile] ← `fedp_d_val` and clear `pending[tile]` at the same edge.
  - If an issue and a writeback to the same tile coincide, the writeback takes priority for acc. This cannot happen under the scoreboard and must be flagged by an assertion.
- **RESP**
  - `rsp_valid` = 1 and `rsp_d` = acc, both held stable until `rsp_ready`.
  - On `rsp_ready`, return to IDLE.
- **Enable and arithmetic**
  - `fedp_enable` = 1 whenever not in IDLE. Bubbles carry valid = 0 in the tracker, so FEDP outputs for bubbles are ignored.
  - Accumulation arithmetic is done entirely by the FEDP. The sequencer only moves 32-bit words.
- **Reset**
  - `reset_n` low, at any time: state → IDLE, and pending, tracker, cursor and acc are all cleared.
  - FEDP results still in flight from before the reset are discarded because the tracker is empty.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `op_ready`, `fedp_enable`, `rsp_valid` = 0.
  - `op_tile` = 0, `fedp_c_val` = 0, `rsp_d` = 0.
  - `fedp_fmt_s`/`fedp_fmt_d` = 0.
- Request accepted at cycle 0 → first possible issue in cycle 1.
- An issue in cycle T has its result visible on `fedp_d_val` in cycle T+LATENCY. It is captured at the end of that cycle, so the same tile may reissue no earlier than T+LATENCY+1.
- Zero-stall throughput requires TILES ≥ LATENCY+1.
- With no stalls, `rsp_valid` rises in cycle TILES×(ksteps+1)+LATENCY+1.
- `op_ready` does not depend on `op_valid`.
- `req_ready` and `rsp_valid` are registered state decodes.

## Configuration
- `VX_TCU_SEQ_PERF_EN`:
  - Defined: adds outputs `perf_issues` (32-bit count of issues) and `perf_stalls` (32-bit count of ISSUE cycles with `op_valid && !op_ready`). Both are cleared by reset, free-running otherwise, and wrap at 2^32.
  - Undefined: neither the ports nor the counters exist.

## Test plan
- **Reset:** assert `reset_n` low mid-ISSUE → all outputs take their reset values immediately. After release, a new job completes correctly, unaffected by stale FEDP outputs.
- **Single step:** int8, N=1, TILES=8, ksteps=0, a=0x01010101, b=0x02020202, all c=5 → `rsp_d` is eight words of 13.
- **Full throughput:** TILES=8, LATENCY=4, ksteps=3, `op_valid` held 1, a=b=0x01010101, c=0 → `op_ready` is never low, and the 32 issues fall in cycles 1–32. `rsp_valid` rises in cycle 37 with every element = 16.
- **Scoreboard stall:** TILES=2, LATENCY=4, ksteps=1, `op_valid` held 1 → issues in cycles 1 and 2, `op_ready` = 0 in cycles 3–5, tile 0 reissues in cycle 6, and results are correct.
- **Bubbles and backpressure:** `op_valid` toggled every other cycle, and `rsp_ready` held low for 5 cycles → results are identical to the no-bubble run. `rsp_d` stays stable while held, and `req_ready` stays 0 until the response handshake.
- **Perf counters** (`VX_TCU_SEQ_PERF_EN`, scoreboard-stall scenario) → `perf_issues` = 4, `perf_stalls` = 3.
